ccff_loader: RTL and testbench

CCFF_LOADER -- requirements
Module: ccff_loader

---
 rtl/ccff_loader.sv | 156 +++++++++++++++
 tb/tb_ccff_loader.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccff_loader.sv
`timescale 1ns/1ps
// ccff_loader
// Streams configuration words into a serial configuration flip-flop chain.
// Each word is shifted LSB first into ccff_head, and CHAIN_LEN bits are
// shifted per load. The bits coming out of ccff_tail are folded into a parity
// bit, which is published on tail_parity when the load completes.
//
// Parameters
//   CHAIN_LEN  chain bits shifted per load (1..65535)
//   WORD_W     width of each configuration word
//   TIMEOUT    idle FETCH cycles tolerated before the load is aborted
//
// Ports
//   prog_clk       configuration clock (rising edge)
//   pReset         asynchronous active-high reset
//   start          single-cycle load request (honoured only in IDLE)
//   cfg_data       configuration word, LSB shifted first
//   cfg_valid      cfg_data valid
//   cfg_ready      loader accepts a word this cycle (FETCH)
//   ccff_head      serial bit into the chain head
//   ccff_shift_en  chain shift enable
//   ccff_tail      serial bit from the chain tail
//   busy           load in progress (FETCH or SHIFT)
//   done           one-cycle pulse on successful completion
//   error          sticky timeout flag, cleared by the next accepted start
//   tail_parity    XOR of all tail bits sampled during the last completed load
module ccff_loader #(
  parameter int CHAIN_LEN = 18,
  parameter int WORD_W    = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              tail_parity
);

  localparam int BW = $clog2(WORD_W + 1);
  localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [15:0]   CHAIN_CNT    = 16'(CHAIN_LEN);
  localparam logic [BW-1:0] WORD_CNT     = BW'(WORD_W);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [15:0]       remaining;
  logic [BW-1:0]     bitcnt;
  logic [TW-1:0]     tcnt;
  logic [WORD_W-1:0] shreg;
  logic              acc;
  logic              hs;
  logic              tmo;

  // Saturating decrements: the counters hold at zero instead of wrapping.
  function automatic logic [15:0] dec_rem(input logic [15:0] v);
    return (v == 16'd0) ? v : v - 16'd1;
  endfunction

  function automatic logic [BW-1:0] dec_bit(input logic [BW-1:0] v);
    return (v == '0) ? v : v - BW'(1);
  endfunction

  assign hs  = (state == FETCH) && cfg_valid;
  // The cycle that would bring the idle counter to TIMEOUT ends the load.
  assign tmo = (state == FETCH) && !cfg_valid && (tcnt == TIMEOUT_LAST);

  // Outputs are decoded from registered state only; the head bit is gated
  // so the chain input is quiet whenever the enable is low.
  assign cfg_ready     = (state == FETCH);
  assign ccff_shift_en = (state == SHIFT);
  assign ccff_head     = (state == SHIFT) && shreg[0];
  assign busy          = (state == FETCH) || (state == SHIFT);
  assign done          = (state == DONE);

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (start) state_nxt = FETCH;
      FETCH: begin
        if (hs)       state_nxt = SHIFT;
        else if (tmo) state_nxt = IDLE;
      end
      SHIFT: begin
        // Chain end wins over word end: leftover bits of the last word drop.
        if (remaining <= 16'd1)     state_nxt = DONE;
        else if (bitcnt <= BW'(1))  state_nxt = FETCH;
      end
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      remaining   <= '0;
      bitcnt      <= '0;
      tcnt        <= '0;
      shreg       <= '0;
      acc         <= 1'b0;
      error       <= 1'b0;
      tail_parity <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            remaining <= CHAIN_CNT;
            tcnt      <= '0;
            acc       <= 1'b0;
            error     <= 1'b0;
          end
        end
        FETCH: begin
          if (hs) begin
            shreg  <= cfg_data;
            bitcnt <= WORD_CNT;
            tcnt   <= '0;
          end else begin
            tcnt <= tcnt + TW'(1);
            if (tmo) error <= 1'b1;
          end
        end
        SHIFT: begin
          shreg     <= shreg >> 1;
          remaining <= dec_rem(remaining);
          bitcnt    <= dec_bit(bitcnt);
          acc       <= acc ^ ccff_tail;
        end
        DONE: tail_parity <= acc;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ccff_loader.sv
`timescale 1ns/1ps
module tb_ccff_loader;

  logic       prog_clk = 1'b0;
  logic       pReset;
  logic       start;
  logic [7:0] cfg_data;
  logic       cfg_valid;
  logic       cfg_ready;
  logic       ccff_head;
  logic       ccff_shift_en;
  logic       ccff_tail;
  logic       busy;
  logic       done;
  logic       error;
  logic       tail_parity;

  logic       start1;
  logic [7:0] cfg_data1;
  logic       cfg_valid1;
  logic       cfg_ready1;
  logic       head1;
  logic       shift_en1;
  logic       tail1;
  logic       busy1;
  logic       done1;
  logic       error1;
  logic       tail_parity1;

  int n_checks = 0;
  int n_fail   = 0;

  int   shift_cnt = 0;
  int   done_cnt  = 0;
  int   base      = 0;
  int   dbase     = 0;
  logic head_log [0:1023];
  logic tail_pat [0:31];

  always #5 prog_clk = ~prog_clk;

  ccff_loader #(.CHAIN_LEN(18), .WORD_W(8), .TIMEOUT(4)) u_dut (
    .prog_clk     (prog_clk),
    .pReset       (pReset),
    .start        (start),
    .cfg_data     (cfg_data),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .ccff_head    (ccff_head),
    .ccff_shift_en(ccff_shift_en),
    .ccff_tail    (ccff_tail),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .tail_parity  (tail_parity)
  );

  ccff_loader #(.CHAIN_LEN(1), .WORD_W(8), .TIMEOUT(4)) u_dut1 (
    .prog_clk     (prog_clk),
    .pReset       (pReset),
    .start        (start1),
    .cfg_data     (cfg_data1),
    .cfg_valid    (cfg_valid1),
    .cfg_ready    (cfg_ready1),
    .ccff_head    (head1),
    .ccff_shift_en(shift_en1),
    .ccff_tail    (tail1),
    .busy         (busy1),
    .done         (done1),
    .error        (error1),
    .tail_parity  (tail_parity1)
  );

  // Chain model: logs head bits, supplies tail bits per shift cycle.
  always @(negedge prog_clk) begin
    if (ccff_shift_en) begin
      head_log[shift_cnt & 1023] = ccff_head;
      if ((shift_cnt - base) >= 0 && (shift_cnt - base) < 32)
        ccff_tail = tail_pat[shift_cnt - base];
      else
        ccff_tail = 1'b0;
      shift_cnt++;
    end else begin
      ccff_tail = 1'b0;
    end
    if (done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_tail(input int ones);
    for (int i = 0; i < 32; i++) tail_pat[i] = (i < ones);
  endtask

  function automatic logic [17:0] heads18();
    logic [17:0] r;
    for (int i = 0; i < 18; i++) r[i] = head_log[(base + i) & 1023];
    return r;
  endfunction

  task automatic pulse_start();
    @(negedge prog_clk);
    start = 1'b1;
    @(negedge prog_clk);
    start = 1'b0;
  endtask

  // Holds cfg_valid low for gap cycles, then offers w until it is taken.
  task automatic feed(input logic [7:0] w, input int gap);
    int n = 0;
    repeat (gap) begin
      cfg_valid = 1'b0;
      @(negedge prog_clk);
    end
    cfg_valid = 1'b1;
    cfg_data  = w;
    while (!cfg_ready && n < 100) begin
      @(negedge prog_clk);
      n++;
    end
    if (n >= 100) chk("feed_timeout", 32'(n), 32'd0);
    @(negedge prog_clk);
    cfg_valid = 1'b0;
  endtask

  task automatic full_load(input int ones, input int g0, input int g1, input int g2,
                           input logic mid_start);
    int n = 0;
    set_tail(ones);
    base  = shift_cnt;
    dbase = done_cnt;
    pulse_start();
    feed(8'hA5, g0);
    if (mid_start) begin
      start = 1'b1;
      @(negedge prog_clk);
      start = 1'b0;
    end
    feed(8'h3C, g1);
    feed(8'h02, g2);
    while (done_cnt == dbase && n < 200) begin
      @(negedge prog_clk);
      #1;
      n++;
    end
    repeat (3) @(negedge prog_clk);
    #1;
  endtask

  initial begin
    pReset     = 1'b1;
    start      = 1'b0;
    cfg_valid  = 1'b0;
    cfg_data   = 8'h00;
    start1     = 1'b0;
    cfg_valid1 = 1'b0;
    cfg_data1  = 8'h00;
    tail1      = 1'b0;
    set_tail(0);

    repeat (2) @(negedge prog_clk);
    chk("rst_ready", 32'(cfg_ready), 32'd0);
    chk("rst_shift_en", 32'(ccff_shift_en), 32'd0);
    chk("rst_head", 32'(ccff_head), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_parity", 32'(tail_parity), 32'd0);
    pReset = 1'b0;

    // Nominal load with a start pulse injected mid-load
    full_load(0, 0, 0, 0, 1'b1);
    chk("nom_shifts", 32'(shift_cnt - base), 32'd18);
    chk("nom_heads", 32'(heads18()), 32'h23CA5);
    chk("nom_done", 32'(done_cnt - dbase), 32'd1);
    chk("nom_busy", 32'(busy), 32'd0);
    chk("nom_parity", 32'(tail_parity), 32'd0);
    chk("nom_error", 32'(error), 32'd0);

    // Parity readback
    full_load(5, 0, 0, 0, 1'b0);
    chk("par5", 32'(tail_parity), 32'd1);
    full_load(6, 0, 0, 0, 1'b0);
    chk("par6", 32'(tail_parity), 32'd0);
    full_load(5, 0, 0, 0, 1'b0);
    chk("par5b", 32'(tail_parity), 32'd1);

    // Starvation after the first word
    set_tail(0);
    base  = shift_cnt;
    dbase = done_cnt;
    pulse_start();
    feed(8'hA5, 0);
    repeat (11) @(negedge prog_clk);
    #1;
    chk("starve_err_early", 32'(error), 32'd0);
    chk("starve_busy_early", 32'(busy), 32'd1);
    @(negedge prog_clk);
    #1;
    chk("starve_err", 32'(error), 32'd1);
    chk("starve_busy", 32'(busy), 32'd0);
    chk("starve_ready", 32'(cfg_ready), 32'd0);
    chk("starve_shifts", 32'(shift_cnt - base), 32'd8);
    chk("starve_nodone", 32'(done_cnt - dbase), 32'd0);
    chk("starve_parity_kept", 32'(tail_parity), 32'd1);
    repeat (2) @(negedge prog_clk);
    #1;
    chk("starve_err_sticky", 32'(error), 32'd1);
    base  = shift_cnt;
    dbase = done_cnt;
    pulse_start();
    #1;
    chk("restart_err_clr", 32'(error), 32'd0);
    chk("restart_busy", 32'(busy), 32'd1);
    feed(8'hA5, 0);
    feed(8'h3C, 0);
    feed(8'h02, 0);
    repeat (6) @(negedge prog_clk);
    #1;
    chk("restart_done", 32'(done_cnt - dbase), 32'd1);
    chk("restart_heads", 32'(heads18()), 32'h23CA5);
    chk("restart_parity", 32'(tail_parity), 32'd0);

    // Back-pressure with idle gaps
    full_load(0, 3, 10, 9, 1'b0);
    chk("bp_shifts", 32'(shift_cnt - base), 32'd18);
    chk("bp_heads", 32'(heads18()), 32'h23CA5);
    chk("bp_done", 32'(done_cnt - dbase), 32'd1);
    chk("bp_error", 32'(error), 32'd0);

    // Reset during the tenth shift cycle
    begin
      int n = 0;
      set_tail(0);
      base  = shift_cnt;
      dbase = done_cnt;
      pulse_start();
      feed(8'hA5, 0);
      cfg_data  = 8'h3C;
      cfg_valid = 1'b1;
      while ((shift_cnt - base) != 10 && n < 100) begin
        @(negedge prog_clk);
        #1;
        n++;
      end
      chk("mid_reached", 32'(shift_cnt - base), 32'd10);
      pReset = 1'b1;
      #1;
      chk("mid_shift_en", 32'(ccff_shift_en), 32'd0);
      chk("mid_head", 32'(ccff_head), 32'd0);
      chk("mid_busy", 32'(busy), 32'd0);
      chk("mid_ready", 32'(cfg_ready), 32'd0);
      chk("mid_done", 32'(done), 32'd0);
      cfg_valid = 1'b0;
      repeat (3) @(negedge prog_clk);
      pReset    = 1'b0;
      cfg_valid = 1'b1;
      cfg_data  = 8'hA5;
      repeat (5) @(negedge prog_clk);
      #1;
      chk("mid_idle_busy", 32'(busy), 32'd0);
      chk("mid_idle_ready", 32'(cfg_ready), 32'd0);
      chk("mid_no_more_shift", 32'(shift_cnt - base), 32'd10);
      chk("mid_no_done", 32'(done_cnt - dbase), 32'd0);
      cfg_valid = 1'b0;
    end
    full_load(0, 0, 0, 0, 1'b0);
    chk("post_rst_shifts", 32'(shift_cnt - base), 32'd18);
    chk("post_rst_heads", 32'(heads18()), 32'h23CA5);
    chk("post_rst_done", 32'(done_cnt - dbase), 32'd1);

    // Single-bit chain, second start while busy
    @(negedge prog_clk);
    start1 = 1'b1;
    @(negedge prog_clk);
    start1 = 1'b0;
    #1;
    chk("one_busy", 32'(busy1), 32'd1);
    chk("one_ready", 32'(cfg_ready1), 32'd1);
    start1     = 1'b1;
    cfg_valid1 = 1'b1;
    cfg_data1  = 8'hFF;
    @(negedge prog_clk);
    start1     = 1'b0;
    cfg_valid1 = 1'b0;
    #1;
    chk("one_shift_en", 32'(shift_en1), 32'd1);
    chk("one_head", 32'(head1), 32'd1);
    @(negedge prog_clk);
    #1;
    chk("one_done", 32'(done1), 32'd1);
    chk("one_shift_off", 32'(shift_en1), 32'd0);
    chk("one_busy_done", 32'(busy1), 32'd0);
    @(negedge prog_clk);
    #1;
    chk("one_done_pulse", 32'(done1), 32'd0);
    chk("one_idle", 32'(busy1), 32'd0);
    chk("one_error", 32'(error1), 32'd0);
    chk("one_parity", 32'(tail_parity1), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
